// File: rtl/uart_pkg.sv
// Shared definitions for the host UART link: FSM encodings and header layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_HEADER = 2'd1,
        SEND_BYTE   = 2'd2,
        DONE        = 2'd3
    } tx_state_t;

    // Header tags; the transmitter only ever sends responses.
    localparam logic [1:0] TAG_RESPONSE = 2'b10;
    localparam logic [1:0] TAG_READ     = 2'b01;
    localparam logic [1:0] TAG_WRITE    = 2'b11;

    // Header field positions inside a 12-bit header word.
    localparam int HDR_W       = 12;
    localparam int TAG_HI      = 11;
    localparam int TAG_LO      = 10;
    localparam int MEMTYPE_BIT = 9;
    localparam int ADDR_HI     = 8;
    localparam int ADDR_LO     = 0;

    // Build a header word from its fields.
    function automatic logic [HDR_W-1:0] build_header(input logic [1:0] tag,
                                                      input logic       mem_type,
                                                      input logic [8:0] addr);
        logic [HDR_W-1:0] h;
        h                  = '0;
        h[TAG_HI:TAG_LO]   = tag;
        h[MEMTYPE_BIT]     = mem_type;
        h[ADDR_HI:ADDR_LO] = addr;
        return h;
    endfunction

endpackage

// File: rtl/uart_bytes_tx_if.sv
// Request/status bundle between the memory bridge and the UART transmitter.
interface uart_bytes_tx_if;
    logic        start;
    logic [31:0] data_in;
    logic [8:0]  target_addr;
    logic        target_mem_type;
    logic        busy;
    logic        done;

    // Bridge side: issues requests, watches status.
    modport master (
        output start, data_in, target_addr, target_mem_type,
        input  busy, done
    );

    // Transmitter side.
    modport slave (
        input  start, data_in, target_addr, target_mem_type,
        output busy, done
    );
endinterface

// File: rtl/uart_bits_tx.sv
// Serialises one frame: start bit 0, DATA_BITS data bits LSB first, stop bit 1.
// A load in the last stop-bit cycle chains the next frame with no idle gap.
module uart_bits_tx #(
    parameter int DATA_BITS    = 12,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] frame_in,
    output logic                 tx,
    output logic                 frame_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 2);

    // Shift register holds the remaining data bits plus the stop bit.
    logic [DATA_BITS:0] shift_q, shift_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic               active_q, active_d;
    logic               tx_q, tx_d;
    logic               last_baud, last_bit;

    assign last_baud  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_bit   = (bit_q == BIT_W'(DATA_BITS + 1));
    assign frame_done = active_q && last_baud && last_bit;
    assign tx         = tx_q;

    // Next-state: load wins over everything, otherwise advance baud/bit timing.
    always_comb begin
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_d   = baud_q;
        active_d = active_q;
        tx_d     = tx_q;
        if (load) begin
            shift_d  = {1'b1, frame_in};
            bit_d    = '0;
            baud_d   = '0;
            active_d = 1'b1;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (!last_baud) begin
                baud_d = baud_q + 1'b1;
            end else begin
                baud_d = '0;
                if (last_bit) begin
                    active_d = 1'b0;
                    bit_d    = '0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[DATA_BITS:1]};
                end
            end
        end
    end

    // State registers; reset parks the line idle high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: rtl/uart_bytes_tx.sv
// Response packet sender: header frame then BYTE_COUNT data frames, MSB byte first.
module uart_bytes_tx
    import uart_pkg::*;
#(
    parameter int BYTE_COUNT   = 4,
    parameter int DATA_BITS    = 12,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            reset,
    uart_bytes_tx_if.slave  req,
    output logic            tx
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTE_COUNT - 1);

    tx_state_t            state_q, state_d;
    logic [1:0]           byte_q, byte_d;
    logic [31:0]          data_q;
    logic [8:0]           addr_q;
    logic                 mem_q;
    logic                 accept;
    logic                 load;
    logic [DATA_BITS-1:0] frame;
    logic                 frame_done;

    // Byte idx of the packet payload, most significant first.
    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] idx);
        int sh;
        sh = 8 * (BYTE_COUNT - 1 - int'(idx));
        return 8'(d >> sh);
    endfunction

    // busy==0 exactly in IDLE and DONE, so a start in the done cycle is taken.
    assign accept   = req.start && (state_q == IDLE || state_q == DONE);
    assign req.busy = (state_q == SEND_HEADER) || (state_q == SEND_BYTE);
    assign req.done = (state_q == DONE);

    // Sequencing: load the next frame in the last stop-bit cycle of the current one.
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        load    = 1'b0;
        frame   = '0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req.start) begin
                    // Header is built from the live inputs; they are latched on this edge.
                    state_d = SEND_HEADER;
                    byte_d  = '0;
                    load    = 1'b1;
                    frame   = DATA_BITS'(build_header(TAG_RESPONSE, req.target_mem_type,
                                                      req.target_addr));
                end
            end
            SEND_HEADER: begin
                if (frame_done) begin
                    state_d = SEND_BYTE;
                    load    = 1'b1;
                    frame   = DATA_BITS'(pick_byte(data_q, 2'd0));
                end
            end
            SEND_BYTE: begin
                if (frame_done) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = DONE;
                    end else begin
                        byte_d = byte_q + 2'd1;
                        load   = 1'b1;
                        frame  = DATA_BITS'(pick_byte(data_q, byte_q + 2'd1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and byte counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
        end
    end

    // Request capture on acceptance only; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            addr_q <= '0;
            mem_q  <= 1'b0;
        end else if (accept) begin
            data_q <= req.data_in;
            addr_q <= req.target_addr;
            mem_q  <= req.target_mem_type;
        end
    end

    uart_bits_tx #(
        .DATA_BITS   (DATA_BITS),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bits (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .frame_in  (frame),
        .tx        (tx),
        .frame_done(frame_done)
    );

    // Address and memory type only travel in the header, which is built from
    // the live inputs; the captured copies are kept for observability.
    logic unused_ok;
    assign unused_ok = ^{addr_q, mem_q};
endmodule
